// File: rtl/cmprs_frame_sync_mchn.sv
// cmprs_frame_sync_mchn: per-channel frame synchroniser between the sensor
// (source) and compressor (destination) memory channels. Each channel
// generates compressor frame starts, throttles compressor reads behind the
// source, flags broken/aborted frames for a flush, keeps the compressor alive
// through shutdown and counts broken frames. Channels are fully independent.
module cmprs_frame_sync_mchn #(
    parameter int NUM_CHN            = 4,
    parameter int FRAME_HEIGHT_BITS  = 16,
    parameter int LAST_FRAME_BITS    = 16,
    parameter int LINE_MARGIN        = 2,
    parameter int CMPRS_TIMEOUT_BITS = 12,
    parameter int CMPRS_TIMEOUT      = 1000,
    parameter int BROKEN_CNT_BITS    = 8
) (
    input  logic                                   mclk,
    input  logic                                   mrst,
    input  logic [NUM_CHN-1:0]                     cmprs_en,
    input  logic [NUM_CHN-1:0]                     cmprs_run,
    input  logic [NUM_CHN-1:0]                     cmprs_standalone,
    input  logic [NUM_CHN-1:0]                     single_frame_buf,
    input  logic [NUM_CHN-1:0]                     vsync_late,
    input  logic [NUM_CHN-1:0]                     frame_started,
    input  logic [NUM_CHN*FRAME_HEIGHT_BITS-1:0]   line_unfinished_src,
    input  logic [NUM_CHN*LAST_FRAME_BITS-1:0]     frame_number_src,
    input  logic [NUM_CHN-1:0]                     frame_done_src,
    input  logic [NUM_CHN*FRAME_HEIGHT_BITS-1:0]   line_unfinished,
    input  logic [NUM_CHN*LAST_FRAME_BITS-1:0]     frame_number,
    input  logic [NUM_CHN-1:0]                     frame_done,
    input  logic [NUM_CHN-1:0]                     stuffer_running,
    output logic [NUM_CHN-1:0]                     cmprs_en_extend,
    output logic [NUM_CHN-1:0]                     frame_start_dst,
    output logic [NUM_CHN-1:0]                     suspend,
    output logic [NUM_CHN-1:0]                     force_flush_long,
    output logic [NUM_CHN-1:0]                     reading_frame,
    output logic [NUM_CHN*BROKEN_CNT_BITS-1:0]     broken_cnt
);
    typedef enum logic [1:0] {ST_OFF, ST_IDLE, ST_READ, ST_DRAIN} state_t;

    localparam int FHB = FRAME_HEIGHT_BITS;
    localparam int LFB = LAST_FRAME_BITS;
    localparam int BCB = BROKEN_CNT_BITS;
    localparam int CTB = CMPRS_TIMEOUT_BITS;
    localparam logic [CTB-1:0] TIMEOUT_LOAD = CTB'(CMPRS_TIMEOUT);
    // One extra bit so that dst_line + margin never wraps around
    localparam logic [FHB:0]   MARGIN       = (FHB+1)'(LINE_MARGIN);

    // Saturating increment for the broken-frame counter
    function automatic logic [BCB-1:0] sat_inc(input logic [BCB-1:0] v);
        return (&v) ? v : v + BCB'(1);
    endfunction

    for (genvar c = 0; c < NUM_CHN; c++) begin : g_chn
        logic           en, run, standalone, sfb, vsync, started;
        logic           done_src, done, stuffer;
        logic [FHB-1:0] line_src, line_dst;
        logic [LFB-1:0] fnum_src, fnum_dst;

        assign en         = cmprs_en[c];
        assign run        = cmprs_run[c];
        assign standalone = cmprs_standalone[c];
        assign sfb        = single_frame_buf[c];
        assign vsync      = vsync_late[c];
        assign started    = frame_started[c];
        assign done_src   = frame_done_src[c];
        assign done       = frame_done[c];
        assign stuffer    = stuffer_running[c];
        assign line_src   = line_unfinished_src[c*FHB +: FHB];
        assign line_dst   = line_unfinished[c*FHB +: FHB];
        assign fnum_src   = frame_number_src[c*LFB +: LFB];
        assign fnum_dst   = frame_number[c*LFB +: LFB];

        state_t         state;
        logic           en_ext_r, reading_r, en_p1, bonded, frames_differ;
        logic           start_r, suspend_r, flush_req_p1, flush_r;
        logic [CTB-1:0] timeout;
        logic [BCB-1:0] broken_r;

        logic brk, abort, src_ahead, line_ok, flush_clr;

        // A new source frame arriving while the compressor still reads the old one
        assign brk       = en & run & vsync & reading_r;
        // Enable dropped while the stuffer is still busy with a frame
        assign abort     = en_p1 & ~en & stuffer;
        assign src_ahead = sfb ? frames_differ : (fnum_src != fnum_dst);
        assign line_ok   = {1'b0, line_src} > ({1'b0, line_dst} + MARGIN);
        assign flush_clr = ~stuffer | (state == ST_OFF);

        // Channel FSM with registered enable-extend and reading outputs
        always_ff @(posedge mclk) begin
            if (mrst) begin
                state     <= ST_OFF;
                en_ext_r  <= 1'b0;
                reading_r <= 1'b0;
            end else begin
                case (state)
                    ST_OFF: begin
                        if (en) begin
                            state    <= ST_IDLE;
                            en_ext_r <= 1'b1;
                        end
                    end
                    ST_IDLE: begin
                        if (!en) begin
                            state <= ST_DRAIN;
                        end else if (started) begin
                            state     <= ST_READ;
                            reading_r <= 1'b1;
                        end
                    end
                    ST_READ: begin
                        if (!en) begin
                            state     <= ST_DRAIN;
                            reading_r <= 1'b0;
                        end else if (done || (run && vsync)) begin
                            state     <= ST_IDLE;
                            reading_r <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        if (en) begin
                            state <= ST_IDLE;
                        end else if (!stuffer || (timeout == '0)) begin
                            state    <= ST_OFF;
                            en_ext_r <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= ST_OFF;
                        en_ext_r  <= 1'b0;
                        reading_r <= 1'b0;
                    end
                endcase
            end
        end

        // Shutdown timeout: armed while enabled, counts down while draining
        always_ff @(posedge mclk) begin
            if (mrst) begin
                timeout <= '0;
            end else if (en) begin
                timeout <= TIMEOUT_LOAD;
            end else if (state == ST_OFF) begin
                timeout <= '0;
            end else if ((state == ST_DRAIN) && (timeout != '0)) begin
                timeout <= timeout - CTB'(1);
            end
        end

        // Enable history, bonded-mode flag and source-frame-ahead flag
        always_ff @(posedge mclk) begin
            if (mrst) begin
                en_p1         <= 1'b0;
                bonded        <= 1'b0;
                frames_differ <= 1'b0;
            end else begin
                en_p1 <= en;
                if (!en)             bonded <= 1'b0;
                else if (run)        bonded <= 1'b1;
                else if (standalone) bonded <= 1'b0;
                if (!en || !run || vsync) frames_differ <= 1'b0;
                else if (done_src)        frames_differ <= 1'b1;
            end
        end

        // Compressor frame trigger and read throttling
        always_ff @(posedge mclk) begin
            if (mrst) begin
                start_r   <= 1'b0;
                suspend_r <= 1'b0;
            end else begin
                start_r   <= en & (run ? (vsync & ~reading_r) : standalone);
                suspend_r <= en & bonded & ~(src_ahead | line_ok);
            end
        end

        // p0 -> p1: broken/aborted event captured; p1 -> p2: flush level updated
        always_ff @(posedge mclk) begin
            if (mrst) begin
                flush_req_p1 <= 1'b0;
                flush_r      <= 1'b0;
            end else begin
                flush_req_p1 <= brk | abort;
                if (flush_clr)         flush_r <= 1'b0;
                else if (flush_req_p1) flush_r <= 1'b1;
            end
        end

        // Broken-frame counter, restarted whenever the channel is re-enabled
        always_ff @(posedge mclk) begin
            if (mrst) begin
                broken_r <= '0;
            end else if (en && !en_p1) begin
                broken_r <= '0;
            end else if (brk) begin
                broken_r <= sat_inc(broken_r);
            end
        end

        assign cmprs_en_extend[c]          = en_ext_r;
        assign frame_start_dst[c]          = start_r;
        assign suspend[c]                  = suspend_r;
        assign force_flush_long[c]         = flush_r;
        assign reading_frame[c]            = reading_r;
        assign broken_cnt[c*BCB +: BCB]    = broken_r;
    end

endmodule

// File: tb/tb_cmprs_frame_sync_mchn.sv
// Testbench for cmprs_frame_sync_mchn: scenario tasks with a frame-start scoreboard.
module tb_cmprs_frame_sync_mchn;
    localparam int NUM_CHN = 4;
    localparam int FHB     = 16;
    localparam int LFB     = 16;
    localparam int BCB     = 2;
    localparam int CTO     = 20;

    logic                     mclk = 1'b0;
    logic                     mrst;
    logic [NUM_CHN-1:0]       cmprs_en, cmprs_run, cmprs_standalone, single_frame_buf;
    logic [NUM_CHN-1:0]       vsync_late, frame_started, frame_done_src, frame_done;
    logic [NUM_CHN-1:0]       stuffer_running;
    logic [NUM_CHN*FHB-1:0]   line_unfinished_src, line_unfinished;
    logic [NUM_CHN*LFB-1:0]   frame_number_src, frame_number;
    logic [NUM_CHN-1:0]       cmprs_en_extend, frame_start_dst, suspend;
    logic [NUM_CHN-1:0]       force_flush_long, reading_frame;
    logic [NUM_CHN*BCB-1:0]   broken_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    // Expected frame_start_dst vector for the next checked cycle
    logic [NUM_CHN-1:0] exp_q[$];
    logic [NUM_CHN-1:0] exp_fs;

    cmprs_frame_sync_mchn #(
        .NUM_CHN(NUM_CHN), .FRAME_HEIGHT_BITS(FHB), .LAST_FRAME_BITS(LFB),
        .LINE_MARGIN(2), .CMPRS_TIMEOUT_BITS(12), .CMPRS_TIMEOUT(CTO),
        .BROKEN_CNT_BITS(BCB)
    ) dut (
        .mclk(mclk), .mrst(mrst),
        .cmprs_en(cmprs_en), .cmprs_run(cmprs_run), .cmprs_standalone(cmprs_standalone),
        .single_frame_buf(single_frame_buf), .vsync_late(vsync_late),
        .frame_started(frame_started), .line_unfinished_src(line_unfinished_src),
        .frame_number_src(frame_number_src), .frame_done_src(frame_done_src),
        .line_unfinished(line_unfinished), .frame_number(frame_number),
        .frame_done(frame_done), .stuffer_running(stuffer_running),
        .cmprs_en_extend(cmprs_en_extend), .frame_start_dst(frame_start_dst),
        .suspend(suspend), .force_flush_long(force_flush_long),
        .reading_frame(reading_frame), .broken_cnt(broken_cnt)
    );

    always #5 mclk = ~mclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic test_reset();
        mrst = 1'b1;
        cmprs_en = '0; cmprs_run = '0; cmprs_standalone = '0; single_frame_buf = '0;
        vsync_late = '0; frame_started = '0; frame_done_src = '0; frame_done = '0;
        stuffer_running = '0;
        line_unfinished_src = '0; line_unfinished = '0;
        frame_number_src = '0; frame_number = '0;
        tick(); tick();
        n_checks++; if (cmprs_en_extend !== '0) begin n_fail++; $display("FAIL reset_en_extend: got %h expected 0", cmprs_en_extend); end
        n_checks++; if (frame_start_dst !== '0) begin n_fail++; $display("FAIL reset_frame_start: got %h expected 0", frame_start_dst); end
        n_checks++; if (suspend !== '0) begin n_fail++; $display("FAIL reset_suspend: got %h expected 0", suspend); end
        n_checks++; if (force_flush_long !== '0) begin n_fail++; $display("FAIL reset_flush: got %h expected 0", force_flush_long); end
        n_checks++; if (reading_frame !== '0) begin n_fail++; $display("FAIL reset_reading: got %h expected 0", reading_frame); end
        n_checks++; if (broken_cnt !== '0) begin n_fail++; $display("FAIL reset_broken_cnt: got %h expected 0", broken_cnt); end
        mrst = 1'b0;
    endtask

    task automatic test_bonded_start();
        cmprs_en[0] = 1'b1; cmprs_run[0] = 1'b1; stuffer_running[0] = 1'b1;
        exp_q.push_back(4'b0000);
        tick();
        exp_fs = exp_q.pop_front();
        n_checks++; if (frame_start_dst !== exp_fs) begin n_fail++; $display("FAIL start_idle: got %b expected %b", frame_start_dst, exp_fs); end
        n_checks++; if (cmprs_en_extend[0] !== 1'b1) begin n_fail++; $display("FAIL start_en_extend: got %b expected 1", cmprs_en_extend[0]); end
        vsync_late[0] = 1'b1;
        exp_q.push_back(4'b0001);
        tick();
        vsync_late[0] = 1'b0;
        exp_fs = exp_q.pop_front();
        n_checks++; if (frame_start_dst !== exp_fs) begin n_fail++; $display("FAIL start_pulse: got %b expected %b", frame_start_dst, exp_fs); end
        exp_q.push_back(4'b0000);
        tick();
        exp_fs = exp_q.pop_front();
        n_checks++; if (frame_start_dst !== exp_fs) begin n_fail++; $display("FAIL start_one_cycle: got %b expected %b", frame_start_dst, exp_fs); end
        frame_started[0] = 1'b1;
        tick();
        frame_started[0] = 1'b0;
        n_checks++; if (reading_frame[0] !== 1'b1) begin n_fail++; $display("FAIL start_reading: got %b expected 1", reading_frame[0]); end
    endtask

    task automatic test_suspend();
        line_unfinished_src[0 +: FHB] = 16'd10; line_unfinished[0 +: FHB] = 16'd8;
        frame_number_src[0 +: LFB] = 16'd4;     frame_number[0 +: LFB] = 16'd4;
        tick();
        n_checks++; if (suspend[0] !== 1'b1) begin n_fail++; $display("FAIL susp_margin_eq: got %b expected 1", suspend[0]); end
        line_unfinished_src[0 +: FHB] = 16'd11;
        tick();
        n_checks++; if (suspend[0] !== 1'b0) begin n_fail++; $display("FAIL susp_line_ahead: got %b expected 0", suspend[0]); end
        line_unfinished_src[0 +: FHB] = 16'd10; frame_number_src[0 +: LFB] = 16'd5;
        tick();
        n_checks++; if (suspend[0] !== 1'b0) begin n_fail++; $display("FAIL susp_frame_ahead: got %b expected 0", suspend[0]); end
        single_frame_buf[0] = 1'b1;
        tick();
        n_checks++; if (suspend[0] !== 1'b1) begin n_fail++; $display("FAIL susp_sfb_same: got %b expected 1", suspend[0]); end
        frame_done_src[0] = 1'b1;
        tick();
        frame_done_src[0] = 1'b0;
        tick();
        n_checks++; if (suspend[0] !== 1'b0) begin n_fail++; $display("FAIL susp_sfb_done: got %b expected 0", suspend[0]); end
        single_frame_buf[0] = 1'b0; frame_number_src[0 +: LFB] = 16'd4;
        line_unfinished_src[0 +: FHB] = 16'hFFFF; line_unfinished[0 +: FHB] = 16'hFFFE;
        tick();
        n_checks++; if (suspend[0] !== 1'b1) begin n_fail++; $display("FAIL susp_no_wrap: got %b expected 1", suspend[0]); end
        line_unfinished[0 +: FHB] = 16'hFFFC;
        tick();
        n_checks++; if (suspend[0] !== 1'b0) begin n_fail++; $display("FAIL susp_top_lines: got %b expected 0", suspend[0]); end
    endtask

    task automatic test_broken();
        n_checks++; if (reading_frame[0] !== 1'b1) begin n_fail++; $display("FAIL brk_pre_reading: got %b expected 1", reading_frame[0]); end
        vsync_late[0] = 1'b1;
        exp_q.push_back(4'b0000);
        tick();
        vsync_late[0] = 1'b0;
        exp_fs = exp_q.pop_front();
        n_checks++; if (frame_start_dst !== exp_fs) begin n_fail++; $display("FAIL brk_no_start: got %b expected %b", frame_start_dst, exp_fs); end
        n_checks++; if (force_flush_long[0] !== 1'b0) begin n_fail++; $display("FAIL brk_flush_t1: got %b expected 0", force_flush_long[0]); end
        n_checks++; if (reading_frame[0] !== 1'b0) begin n_fail++; $display("FAIL brk_read_end: got %b expected 0", reading_frame[0]); end
        tick();
        n_checks++; if (force_flush_long[0] !== 1'b1) begin n_fail++; $display("FAIL brk_flush_t2: got %b expected 1", force_flush_long[0]); end
        n_checks++; if (broken_cnt[0 +: BCB] !== 2'd1) begin n_fail++; $display("FAIL brk_count: got %0d expected 1", broken_cnt[0 +: BCB]); end
        stuffer_running[0] = 1'b0;
        tick();
        n_checks++; if (force_flush_long[0] !== 1'b0) begin n_fail++; $display("FAIL brk_flush_clear: got %b expected 0", force_flush_long[0]); end
        stuffer_running[0] = 1'b1;
        tick();
    endtask

    task automatic test_standalone();
        cmprs_en[2] = 1'b1; cmprs_run[2] = 1'b1;
        tick(); tick();
        n_checks++; if (suspend[2] !== 1'b1) begin n_fail++; $display("FAIL sa_bonded_susp: got %b expected 1", suspend[2]); end
        cmprs_run[2] = 1'b0; cmprs_standalone[2] = 1'b1; cmprs_standalone[3] = 1'b1;
        exp_q.push_back(4'b0100);
        tick();
        cmprs_standalone[2] = 1'b0; cmprs_standalone[3] = 1'b0;
        exp_fs = exp_q.pop_front();
        n_checks++; if (frame_start_dst !== exp_fs) begin n_fail++; $display("FAIL sa_start: got %b expected %b", frame_start_dst, exp_fs); end
        tick();
        n_checks++; if (suspend[2] !== 1'b0) begin n_fail++; $display("FAIL sa_no_susp: got %b expected 0", suspend[2]); end
        n_checks++; if (suspend[3] !== 1'b0) begin n_fail++; $display("FAIL sa_disabled_susp: got %b expected 0", suspend[3]); end
        cmprs_run[2] = 1'b1; cmprs_standalone[2] = 1'b1;
        exp_q.push_back(4'b0000);
        tick();
        cmprs_standalone[2] = 1'b0;
        exp_fs = exp_q.pop_front();
        n_checks++; if (frame_start_dst !== exp_fs) begin n_fail++; $display("FAIL sa_run_prio_start: got %b expected %b", frame_start_dst, exp_fs); end
        tick();
        n_checks++; if (suspend[2] !== 1'b1) begin n_fail++; $display("FAIL sa_run_prio_bond: got %b expected 1", suspend[2]); end
        cmprs_run[2] = 1'b0; cmprs_en[2] = 1'b0;
        tick();
    endtask

    task automatic test_shutdown();
        int n;
        cmprs_en[0] = 1'b0; cmprs_run[0] = 1'b0;
        tick(); tick();
        n = 2;
        n_checks++; if (force_flush_long[0] !== 1'b1) begin n_fail++; $display("FAIL shut_flush: got %b expected 1", force_flush_long[0]); end
        for (int i = 0; i < 40 && cmprs_en_extend[0] === 1'b1; i++) begin
            tick();
            n++;
        end
        n_checks++; if (cmprs_en_extend[0] !== 1'b0) begin n_fail++; $display("FAIL shut_timeout_expired: got %b expected 0", cmprs_en_extend[0]); end
        n_checks++; if (n < CTO + 1 || n > CTO + 2) begin n_fail++; $display("FAIL shut_cycles: got %0d expected %0d..%0d", n, CTO + 1, CTO + 2); end
        tick();
        n_checks++; if (force_flush_long[0] !== 1'b0) begin n_fail++; $display("FAIL shut_flush_off: got %b expected 0", force_flush_long[0]); end
    endtask

    task automatic test_saturation();
        cmprs_en[1] = 1'b1; cmprs_run[1] = 1'b1; stuffer_running[1] = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            frame_started[1] = 1'b1;
            tick();
            frame_started[1] = 1'b0;
            vsync_late[1] = 1'b1;
            exp_q.push_back(4'b0000);
            tick();
            vsync_late[1] = 1'b0;
            exp_fs = exp_q.pop_front();
            n_checks++; if (frame_start_dst !== exp_fs) begin n_fail++; $display("FAIL sat_no_start[%0d]: got %b expected %b", k, frame_start_dst, exp_fs); end
            tick();
        end
        n_checks++; if (broken_cnt[2 +: BCB] !== 2'd3) begin n_fail++; $display("FAIL sat_ch1: got %0d expected 3", broken_cnt[2 +: BCB]); end
        n_checks++; if (broken_cnt[0 +: BCB] !== 2'd1) begin n_fail++; $display("FAIL sat_ch0_kept: got %0d expected 1", broken_cnt[0 +: BCB]); end
        n_checks++; if (broken_cnt[4 +: 2*BCB] !== 4'd0) begin n_fail++; $display("FAIL sat_ch23: got %h expected 0", broken_cnt[4 +: 2*BCB]); end
    endtask

    task automatic test_mrst_mid_frame();
        frame_started[1] = 1'b1;
        tick();
        frame_started[1] = 1'b0;
        n_checks++; if (reading_frame[1] !== 1'b1) begin n_fail++; $display("FAIL rst_pre_reading: got %b expected 1", reading_frame[1]); end
        vsync_late[1] = 1'b1;
        tick();
        vsync_late[1] = 1'b0;
        mrst = 1'b1;
        tick();
        mrst = 1'b0;
        n_checks++; if (cmprs_en_extend !== '0) begin n_fail++; $display("FAIL rst_en_extend: got %h expected 0", cmprs_en_extend); end
        n_checks++; if (reading_frame !== '0) begin n_fail++; $display("FAIL rst_reading: got %h expected 0", reading_frame); end
        n_checks++; if (force_flush_long !== '0) begin n_fail++; $display("FAIL rst_flush: got %h expected 0", force_flush_long); end
        n_checks++; if (broken_cnt !== '0) begin n_fail++; $display("FAIL rst_broken_cnt: got %h expected 0", broken_cnt); end
        n_checks++; if ((suspend | frame_start_dst) !== '0) begin n_fail++; $display("FAIL rst_susp_start: got %h expected 0", suspend | frame_start_dst); end
        tick();
        n_checks++; if (force_flush_long[1] !== 1'b0) begin n_fail++; $display("FAIL rst_no_flush_req: got %b expected 0", force_flush_long[1]); end
        n_checks++; if (cmprs_en_extend[1] !== 1'b1) begin n_fail++; $display("FAIL rst_reenable: got %b expected 1", cmprs_en_extend[1]); end
    endtask

    initial begin
        test_reset();
        test_bonded_start();
        test_suspend();
        test_broken();
        test_standalone();
        test_shutdown();
        test_saturation();
        test_mrst_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
